// File: rtl/capture_pkg.sv
// Shared types for the input-capture stage: edge-select codes,
// capture record layout and the edge-match helper.
package capture_pkg;

   localparam int unsigned CAP_BIN = 32;

   typedef enum logic [1:0] {
      EDGE_NONE = 2'b00,
      EDGE_RISE = 2'b01,
      EDGE_FALL = 2'b10,
      EDGE_BOTH = 2'b11
   } edge_sel_e;

   typedef struct packed {
      logic [CAP_BIN-1:0] value;
      logic               ovf;
   } cap_rec_t;

   function automatic logic edge_hit(
      input edge_sel_e sel,
      input logic      rise,
      input logic      fall
   );
      logic hit;
      unique case (sel)
         EDGE_RISE: hit = rise;
         EDGE_FALL: hit = fall;
         EDGE_BOTH: hit = rise | fall;
         default:   hit = 1'b0;
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/capture_fifo.sv
// Registered synchronous FIFO; push when full is accepted only
// together with a pop, pop when empty is ignored.
module capture_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       wdata,
   output logic [WIDTH-1:0]       rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [LW-1:0]    cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign full  = (cnt_q == LW'(DEPTH));
   assign empty = (cnt_q == '0);
   assign level = cnt_q;
   assign rdata = mem_q[rptr_q];

   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_comb begin
      mem_d = mem_q;
      if (do_push) mem_d[wptr_q] = wdata;
      wptr_d = wptr_q + AW'(do_push);
      rptr_d = rptr_q + AW'(do_pop);
      cnt_d  = cnt_q + LW'(do_push) - LW'(do_pop);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_q  <= '{default: '0};
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         mem_q  <= mem_d;
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/capture_unit.sv
// Input capture: sync, optional glitch filter (CAPTURE_FILTER_EN),
// edge detect, overflow tracking and a record FIFO with lost flag.
module capture_unit
   import capture_pkg::*;
#(
   parameter int BIN      = 32,
   parameter int DEPTH    = 4,
   parameter int FILT_LEN = 3
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   enable,
   input  logic [1:0]             edge_sel,
   input  logic [BIN-1:0]         counter_in,
   input  logic                   ovf_in,
   input  logic                   cap_in,
   output logic [BIN-1:0]         cap_data,
   output logic                   cap_ovf,
   output logic                   cap_valid,
   input  logic                   cap_ready,
   output logic [$clog2(DEPTH):0] level,
   output logic                   lost,
   input  logic                   lost_clr
);

   if (FILT_LEN < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_cfg
      $error("capture_unit: bad DEPTH or FILT_LEN");
   end

   logic sync1_q, pin_s_q, pin_d_q;
   logic rise_q, rise_d, fall_q, fall_d;
   logic ovf_seen_q, ovf_seen_d;
   logic lost_q, lost_d;
   logic src, cap_event, drop;
   logic fifo_full, fifo_empty;
   logic [BIN:0] head;

`ifdef CAPTURE_FILTER_EN
   localparam int FCW = $clog2(FILT_LEN + 1);

   logic           filt_q, filt_d;
   logic [FCW-1:0] fcnt_q, fcnt_d;

   // Output flips only after FILT_LEN agreeing samples that differ from it.
   always_comb begin
      filt_d = filt_q;
      fcnt_d = '0;
      if (pin_s_q != filt_q) begin
         if (fcnt_q == FCW'(FILT_LEN - 1)) filt_d = pin_s_q;
         else fcnt_d = fcnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         filt_q <= 1'b0;
         fcnt_q <= '0;
      end else begin
         filt_q <= filt_d;
         fcnt_q <= fcnt_d;
      end
   end

   assign src = filt_q;
`else
   assign src = pin_s_q;
`endif

   assign rise_d    = src & ~pin_d_q;
   assign fall_d    = ~src & pin_d_q;
   assign cap_event = enable & edge_hit(edge_sel_e'(edge_sel), rise_q, fall_q);
   assign drop      = cap_event & fifo_full & ~cap_ready;

   always_comb begin
      ovf_seen_d = ovf_seen_q;
      if (!enable) ovf_seen_d = 1'b0;
      else if (cap_event) ovf_seen_d = 1'b0;
      else if (ovf_in) ovf_seen_d = 1'b1;
   end

   // A drop in the same cycle as a clear leaves the flag set.
   always_comb begin
      lost_d = drop | (lost_q & ~lost_clr);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q    <= 1'b0;
         pin_s_q    <= 1'b0;
         pin_d_q    <= 1'b0;
         rise_q     <= 1'b0;
         fall_q     <= 1'b0;
         ovf_seen_q <= 1'b0;
         lost_q     <= 1'b0;
      end else begin
         sync1_q    <= cap_in;
         pin_s_q    <= sync1_q;
         pin_d_q    <= src;
         rise_q     <= rise_d;
         fall_q     <= fall_d;
         ovf_seen_q <= ovf_seen_d;
         lost_q     <= lost_d;
      end
   end

   capture_fifo #(
      .WIDTH (BIN + 1),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (cap_event),
      .pop     (cap_ready),
      .wdata   ({counter_in, ovf_seen_q | ovf_in}),
      .rdata   (head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (level)
   );

   assign cap_data  = head[BIN:1];
   assign cap_ovf   = head[0];
   assign cap_valid = ~fifo_empty;
   assign lost      = lost_q;

endmodule
